sort_controller: RTL and testbench

- FSM that sequences the sorting datapath (RAM, counters i/j, registers A/B, comparator) through an in-place ascending exchange sort.
- Consumes the datapath status flags (zi, zj, AgtB) and drives every datapath control strobe.
- Reports busy, done and a swap count to the host.
- Host-side RAM fill (WrInit) and readback (Rd) bypass this block.

---
 rtl/sort_controller.sv | 129 ++++++++++++
 tb/tb_sort_controller.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sort_controller.sv
// Control FSM for an in-place ascending exchange sort over a K-entry RAM.
// Sequences counters i/j, registers A/B and RAM writes; reports busy/done/swap count.
module sort_controller #(
  parameter int CW = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          zi,
  input  logic          zj,
  input  logic          AgtB,
  output logic          Li,
  output logic          Ei,
  output logic          Lj,
  output logic          Ej,
  output logic          EA,
  output logic          EB,
  output logic          Csel,
  output logic          Bout,
  output logic          Wr,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] swap_count
);

  typedef enum logic [3:0] {
    IDLE,
    LOAD_A,
    LOAD_B,
    CMP,
    SWAP_I,
    SWAP_J,
    RELOAD_A,
    NEXT_J,
    NEXT_I,
    DONE
  } state_t;

  state_t state;

  logic in_sort;
  assign in_sort = (state != IDLE) && (state != DONE);

  // Dropping start while sorting wins over every other transition, and the
  // swap counter is left untouched so the host can see how far it got.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      swap_count <= '0;
    end else if (in_sort && !start) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            swap_count <= '0;
            state      <= LOAD_A;
          end
        end
        LOAD_A:   state <= LOAD_B;
        LOAD_B:   state <= CMP;
        CMP:      state <= AgtB ? SWAP_I : NEXT_J;
        SWAP_I:   state <= SWAP_J;
        SWAP_J: begin
          if (swap_count != '1) begin
            swap_count <= swap_count + CW'(1);
          end
          state <= RELOAD_A;
        end
        RELOAD_A: state <= NEXT_J;
        NEXT_J:   state <= zj ? NEXT_I : LOAD_B;
        NEXT_I:   state <= zi ? DONE : LOAD_A;
        DONE: begin
          if (!start) begin
            state <= IDLE;
          end
        end
        default:  state <= IDLE;
      endcase
    end
  end

  // Strobes decode straight from the state register; the counter increments
  // additionally look at zi/zj so the counters never step past their limits.
  always_comb begin
    Li   = 1'b0;
    Ei   = 1'b0;
    Lj   = 1'b0;
    Ej   = 1'b0;
    EA   = 1'b0;
    EB   = 1'b0;
    Csel = 1'b0;
    Bout = 1'b0;
    Wr   = 1'b0;
    busy = in_sort;
    done = 1'b0;
    case (state)
      IDLE: Li = 1'b1;
      LOAD_A: begin
        Csel = 1'b0;
        EA   = 1'b1;
        Lj   = 1'b1;
      end
      LOAD_B: begin
        Csel = 1'b1;
        EB   = 1'b1;
      end
      SWAP_I: begin
        Csel = 1'b0;
        Bout = 1'b1;
        Wr   = 1'b1;
      end
      SWAP_J: begin
        Csel = 1'b1;
        Bout = 1'b0;
        Wr   = 1'b1;
      end
      RELOAD_A: begin
        Csel = 1'b0;
        EA   = 1'b1;
      end
      NEXT_J: Ej = ~zj;
      NEXT_I: Ei = ~zi;
      DONE:   done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sort_controller.sv
// Bench for sort_controller: behavioural datapath (RAM, i/j, A/B) around the FSM,
// with a done-triggered scoreboard checking swap count, sort length and readback.
module tb_sort_controller;

  localparam int CW = 6;

  typedef struct {
    int             swaps;
    int             cycles;
    logic [7:0][7:0] data;
  } exp_t;

  logic          clk;
  logic          rst;
  logic          start;
  logic          zi, zj, AgtB;
  logic          Li, Ei, Lj, Ej, EA, EB, Csel, Bout, Wr, busy, done;
  logic [CW-1:0] swap_count;

  logic [7:0] mem [8];
  logic [2:0] ci, cj;
  logic [7:0] ra, rb;
  logic [7:0] dout;
  logic       host_we;
  logic [2:0] host_addr;
  logic [7:0] host_data;

  int checks   = 0;
  int failures = 0;

  exp_t sb_q[$];
  exp_t exp_cur;
  int   busy_cycles = 0;
  int   wr_count    = 0;
  int   strobe_viol = 0;
  logic done_q      = 1'b0;
  logic start_q     = 1'b0;

  logic [7:0] vec_sorted [8] = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7};
  logic [7:0] vec_desc   [8] = '{8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0};
  logic [7:0] vec_rand   [8] = '{8'd5, 8'd3, 8'd8, 8'd1, 8'd8, 8'd0, 8'd2, 8'd9};
  logic [7:0] vec_rand_s [8] = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd5, 8'd8, 8'd8, 8'd9};

  sort_controller #(.CW(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .zi         (zi),
    .zj         (zj),
    .AgtB       (AgtB),
    .Li         (Li),
    .Ei         (Ei),
    .Lj         (Lj),
    .Ej         (Ej),
    .EA         (EA),
    .EB         (EB),
    .Csel       (Csel),
    .Bout       (Bout),
    .Wr         (Wr),
    .busy       (busy),
    .done       (done),
    .swap_count (swap_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Datapath model for K=8: combinational RAM read, registered everything else.
  assign dout = mem[Csel ? cj : ci];
  assign zi   = (ci == 3'd6);
  assign zj   = (cj == 3'd7);
  assign AgtB = (ra > rb);

  always @(posedge clk) begin
    if (host_we) mem[host_addr] <= host_data;
    else if (Wr) mem[Csel ? cj : ci] <= Bout ? rb : ra;
    if (Li) ci <= 3'd0;
    else if (Ei) ci <= ci + 3'd1;
    if (Lj) cj <= ci + 3'd1;
    else if (Ej) cj <= cj + 3'd1;
    if (EA) ra <= dout;
    if (EB) rb <= dout;
  end

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  // Monitor: counts sort cycles and writes, watches strobe exclusivity, and
  // scores each finished sort against the oldest queued expectation.
  always @(negedge clk) begin
    if (start && !start_q) begin
      busy_cycles = 0;
      wr_count    = 0;
    end
    if (busy) busy_cycles++;
    if (Wr) wr_count++;
    if ((Wr || Ei || Ej) && (Li || Lj)) strobe_viol++;
    if (Wr && !busy) strobe_viol++;
    if (done && !done_q) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL sb_unexpected_done actual=1 expected=0");
      end else begin
        exp_cur = sb_q.pop_front();
        check("swap_count", int'(swap_count), exp_cur.swaps);
        check("sort_cycles", busy_cycles, exp_cur.cycles);
        check("wr_count", wr_count, 2 * exp_cur.swaps);
        for (int k = 0; k < 8; k++) begin
          check($sformatf("readback[%0d]", k), int'(mem[k]), int'(exp_cur.data[k]));
        end
      end
    end
    done_q  = done;
    start_q = start;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] v [8]);
    for (int k = 0; k < 8; k++) begin
      step();
      host_we   = 1'b1;
      host_addr = 3'(k);
      host_data = v[k];
    end
    step();
    host_we = 1'b0;
  endtask

  task automatic push_exp(input int s, input int c, input logic [7:0] v [8]);
    exp_t e;
    e.swaps  = s;
    e.cycles = c;
    for (int k = 0; k < 8; k++) e.data[k] = v[k];
    sb_q.push_back(e);
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!done && n < 400) begin
      step();
      n++;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s_timeout actual=%0d expected_below=400", name, n);
    end
  endtask

  task automatic checkOutput(input string name, input logic exp_li, input logic exp_busy,
                             input logic exp_done, input int exp_swaps);
    check({name, "_Li"}, int'(Li), int'(exp_li));
    check({name, "_busy"}, int'(busy), int'(exp_busy));
    check({name, "_done"}, int'(done), int'(exp_done));
    check({name, "_Wr"}, int'(Wr), 0);
    check({name, "_swap_count"}, int'(swap_count), exp_swaps);
  endtask

  initial begin
    int hold_bad;
    int n;
    int wr_after;
    rst     = 1'b0;
    start   = 1'b0;
    host_we = 1'b0;
    host_addr = 3'd0;
    host_data = 8'd0;
    repeat (3) step();
    checkOutput("reset", 1'b1, 1'b0, 1'b0, 0);
    rst = 1'b1;

    $display("[TB] sorted input");
    applyStimulus(vec_sorted);
    push_exp(0, 98, vec_sorted);
    start = 1'b1;
    wait_done("sorted");
    hold_bad = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (done !== 1'b1 || busy || Li || Ei || Lj || Ej || EA || EB || Csel || Bout || Wr)
        hold_bad++;
    end
    check("done_hold", hold_bad, 0);
    start = 1'b0;
    step();
    checkOutput("done_exit", 1'b1, 1'b0, 1'b0, 0);

    $display("[TB] descending input");
    applyStimulus(vec_desc);
    push_exp(28, 182, vec_sorted);
    start = 1'b1;
    wait_done("desc");
    start = 1'b0;
    step();
    checkOutput("desc_exit", 1'b1, 1'b0, 1'b0, 28);

    $display("[TB] mixed input with duplicates");
    applyStimulus(vec_rand);
    push_exp(11, 131, vec_rand_s);
    start = 1'b1;
    wait_done("rand");
    start = 1'b0;
    step();
    checkOutput("rand_exit", 1'b1, 1'b0, 1'b0, 11);

    $display("[TB] abort in cycle 10");
    applyStimulus(vec_rand);
    start = 1'b1;
    repeat (10) step();
    start = 1'b0;
    step();
    checkOutput("abort", 1'b1, 1'b0, 1'b0, 1);
    wr_after = 0;
    for (int k = 0; k < 5; k++) begin
      step();
      if (Wr) wr_after++;
    end
    check("abort_no_wr", wr_after, 0);
    push_exp(10, 128, vec_rand_s);
    start = 1'b1;
    step();
    check("restart_swap_count", int'(swap_count), 0);
    check("restart_busy", int'(busy), 1);
    wait_done("restart");
    start = 1'b0;
    step();

    $display("[TB] async reset during SWAP_I");
    applyStimulus(vec_rand);
    start = 1'b1;
    n = 0;
    while (!(Wr && Bout && swap_count >= CW'(2)) && n < 100) begin
      step();
      n++;
    end
    check("reach_swap_i", int'(Wr && Bout), 1);
    #1;
    rst = 1'b0;
    #1;
    checkOutput("async_reset", 1'b1, 1'b0, 1'b0, 0);
    start = 1'b0;
    step();
    rst = 1'b1;
    step();

    check("strobe_exclusive", strobe_viol, 0);
    check("sb_drained", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
